bp_update_pipe: RTL and testbench



---
 rtl/bp_update_pipe.sv | 91 +++++++++
 tb/tb_bp_update_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bp_update_pipe.sv
// bp_update_pipe: fixed-shift pipeline for branch-predictor updates with counter forwarding and last-stage BTB/mispredict/redirect.
module bp_update_pipe #(
  parameter int PC_W   = 32,
  parameter int CNT_W  = 2,
  parameter int DEPTH  = 2,
  parameter int FWD_EN = 1
) (
  input  logic             stg_clk,
  input  logic             reset,
  input  logic             stg_ena,
  input  logic             stg_x,
  input  logic             in_valid,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_target,
  input  logic [1:0]       in_flag,
  input  logic [PC_W-1:0]  in_fetch_pc,
  input  logic [CNT_W-1:0] in_counter,
  input  logic             in_btb_valid,
  input  logic             in_pred,
  output logic             out_valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [PC_W-1:0]  out_target,
  output logic [CNT_W-1:0] out_counter,
  output logic             out_btb_wr,
  output logic             out_mispred,
  output logic [PC_W-1:0]  out_redirect
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("bp_update_pipe: DEPTH must be 1..4");
  end
  typedef struct packed {
    logic             valid;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  redirect;
    logic [1:0]       flag;
    logic [CNT_W-1:0] counter;
    logic             btb_valid;
    logic             pred;
  } rec_t;
  localparam logic [CNT_W-1:0] CMAX = '1;
  rec_t             stg [DEPTH];
  rec_t             in_rec;
  rec_t             last;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] next_cnt;
  // Walk oldest to youngest so the youngest matching stage wins; the last stage counts even though it drains this edge.
  always_comb begin
    base = in_counter;
    if (FWD_EN != 0)
      for (int k = DEPTH - 1; k >= 0; k--)
        if (stg[k].valid && stg[k].flag[1] && stg[k].pc == in_pc) base = stg[k].counter;
  end
  assign next_cnt = !in_flag[1] ? base :
                    in_flag[0]  ? (base == CMAX ? base : base + CNT_W'(1)) :
                                  (base == '0   ? base : base - CNT_W'(1));
  // Redirect is resolved on capture so it resets to 0 with the rest of the stage.
  always_comb begin
    in_rec           = '0;
    in_rec.valid     = in_valid;
    in_rec.pc        = in_pc;
    in_rec.target    = in_target;
    in_rec.fetch_pc  = in_fetch_pc;
    in_rec.redirect  = in_flag[0] ? in_target : in_pc + PC_W'(4);
    in_rec.flag      = in_flag;
    in_rec.counter   = next_cnt;
    in_rec.btb_valid = in_btb_valid;
    in_rec.pred      = in_pred;
  end
  always_ff @(posedge stg_clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (stg_x) begin
      for (int k = 0; k < DEPTH; k++) stg[k].valid <= 1'b0;
    end else if (stg_ena) begin
      stg[0] <= in_rec;
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
    end
  end
  assign last         = stg[DEPTH-1];
  assign out_valid    = last.valid;
  assign out_pc       = last.pc;
  assign out_target   = last.target;
  assign out_counter  = last.counter;
  assign out_redirect = last.redirect;
  assign out_btb_wr   = last.valid & last.flag[1] & (last.flag[0] | last.btb_valid);
  assign out_mispred  = last.valid & ((last.flag[1] & ((last.pred != last.flag[0]) |
                        (last.flag[0] & (last.fetch_pc != last.target)))) |
                        (~last.flag[1] & last.btb_valid & last.pred));
endmodule

// File: tb/tb_bp_update_pipe.sv
// tb_bp_update_pipe: directed checks of bp_update_pipe at DEPTH=2 with forwarding enabled.
module tb_bp_update_pipe;
  logic        clk = 0;
  logic        reset, stg_ena, stg_x, in_valid, in_btb_valid, in_pred;
  logic [31:0] in_pc, in_target, in_fetch_pc;
  logic [1:0]  in_flag;
  logic [1:0]  in_counter;
  logic        out_valid, out_btb_wr, out_mispred;
  logic [31:0] out_pc, out_target, out_redirect;
  logic [1:0]  out_counter;
  int checks = 0;
  int errors = 0;

  bp_update_pipe #(.PC_W(32), .CNT_W(2), .DEPTH(2), .FWD_EN(1)) dut (
    .stg_clk(clk), .reset(reset), .stg_ena(stg_ena), .stg_x(stg_x),
    .in_valid(in_valid), .in_pc(in_pc), .in_target(in_target), .in_flag(in_flag),
    .in_fetch_pc(in_fetch_pc), .in_counter(in_counter), .in_btb_valid(in_btb_valid),
    .in_pred(in_pred), .out_valid(out_valid), .out_pc(out_pc), .out_target(out_target),
    .out_counter(out_counter), .out_btb_wr(out_btb_wr), .out_mispred(out_mispred),
    .out_redirect(out_redirect)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [1:0] flag, input logic [31:0] fpc, input logic [1:0] cnt,
                       input logic btb, input logic pred);
    in_valid = v; in_pc = pc; in_target = tgt; in_flag = flag;
    in_fetch_pc = fpc; in_counter = cnt; in_btb_valid = btb; in_pred = pred;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
  endtask

  initial begin
    stg_x = 0; stg_ena = 1; reset = 1;
    drive(1, 32'h100, 32'h200, 2'b11, 32'h104, 2'd1, 1'b1, 1'b1);
    #2;
    // 1: reset wins over enable/valid input
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_counter", {30'd0, out_counter}, 32'd0);
    chk("rst_redirect", out_redirect, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_btb_wr", {31'd0, out_btb_wr}, 32'd0);
    reset = 0;
    // 2: basic taken branch, mispredicted
    drive(1, 32'h100, 32'h200, 2'b11, 32'h104, 2'd1, 1'b0, 1'b0);
    step();
    chk("t2_latency", {31'd0, out_valid}, 32'd0);
    bubble();
    step();
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_pc", out_pc, 32'h100);
    chk("t2_target", out_target, 32'h200);
    chk("t2_counter", {30'd0, out_counter}, 32'd2);
    chk("t2_btb_wr", {31'd0, out_btb_wr}, 32'd1);
    chk("t2_mispred", {31'd0, out_mispred}, 32'd1);
    chk("t2_redirect", out_redirect, 32'h200);
    step();
    chk("t2_consumed", {31'd0, out_valid}, 32'd0);
    chk("t2_gate_btb", {31'd0, out_btb_wr}, 32'd0);
    chk("t2_gate_misp", {31'd0, out_mispred}, 32'd0);
    // 3a: back-to-back same PC taken, forwarding from stage 0
    drive(1, 32'h40, 32'h80, 2'b11, 32'h80, 2'd1, 1'b1, 1'b1);
    step();
    drive(1, 32'h40, 32'h80, 2'b11, 32'h80, 2'd1, 1'b1, 1'b1);
    step();
    bubble();
    chk("t3a_first_counter", {30'd0, out_counter}, 32'd2);
    chk("t3a_first_mispred", {31'd0, out_mispred}, 32'd0);
    step();
    chk("t3a_second_counter", {30'd0, out_counter}, 32'd3);
    chk("t3a_redirect", out_redirect, 32'h80);
    // 3b: taken at saturation then not-taken, both read 3
    drive(1, 32'h40, 32'h80, 2'b11, 32'h80, 2'd3, 1'b1, 1'b1);
    step();
    drive(1, 32'h40, 32'h80, 2'b10, 32'h44, 2'd3, 1'b1, 1'b0);
    step();
    bubble();
    chk("t3b_sat_counter", {30'd0, out_counter}, 32'd3);
    step();
    chk("t3b_nt_counter", {30'd0, out_counter}, 32'd2);
    chk("t3b_nt_redirect", out_redirect, 32'h44);
    chk("t3b_nt_btb_wr", {31'd0, out_btb_wr}, 32'd1);
    // 3c: forwarding from the last stage as it drains on the same edge
    step();
    drive(1, 32'h300, 32'h999, 2'b10, 32'h304, 2'd2, 1'b0, 1'b0);
    step();
    bubble();
    step();
    chk("t3c_e_counter", {30'd0, out_counter}, 32'd1);
    chk("t3c_e_btb_wr", {31'd0, out_btb_wr}, 32'd0);
    chk("t3c_e_mispred", {31'd0, out_mispred}, 32'd0);
    chk("t3c_e_redirect", out_redirect, 32'h304);
    drive(1, 32'h300, 32'h999, 2'b10, 32'h304, 2'd2, 1'b0, 1'b0);
    step();
    bubble();
    step();
    chk("t3c_f_counter", {30'd0, out_counter}, 32'd0);
    // 4: stall holds everything for 5 cycles
    drive(1, 32'h500, 32'h0, 2'b00, 32'h504, 2'd2, 1'b1, 1'b1);
    step();
    stg_ena = 0;
    drive(1, 32'h999, 32'h999, 2'b11, 32'h0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stalled_valid", {31'd0, out_valid}, 32'd0);
    end
    stg_ena = 1;
    bubble();
    step();
    chk("t4_exit_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_pc", out_pc, 32'h500);
    chk("t4_counter", {30'd0, out_counter}, 32'd2);
    chk("t4_mispred", {31'd0, out_mispred}, 32'd1);
    chk("t4_btb_wr", {31'd0, out_btb_wr}, 32'd0);
    chk("t4_redirect", out_redirect, 32'h504);
    stg_ena = 0;
    drive(1, 32'h777, 32'h0, 2'b11, 32'h0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_frozen_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_frozen_pc", out_pc, 32'h500);
    end
    stg_ena = 1;
    // 5: flush with stall drops both in-flight records
    drive(1, 32'h600, 32'h0, 2'b00, 32'h604, 2'd1, 1'b0, 1'b0);
    step();
    drive(1, 32'h700, 32'h0, 2'b00, 32'h704, 2'd1, 1'b0, 1'b0);
    step();
    chk("t5_before_pc", out_pc, 32'h600);
    chk("t5_before_valid", {31'd0, out_valid}, 32'd1);
    stg_x = 1; stg_ena = 0;
    drive(1, 32'h650, 32'h0, 2'b00, 32'h654, 2'd1, 1'b0, 1'b0);
    step();
    chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
    stg_x = 0; stg_ena = 1;
    bubble();
    step();
    chk("t5_flushed_stage0", {31'd0, out_valid}, 32'd0);
    drive(1, 32'h800, 32'h900, 2'b11, 32'h900, 2'd0, 1'b1, 1'b1);
    step();
    bubble();
    step();
    chk("t5_after_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_after_counter", {30'd0, out_counter}, 32'd1);
    chk("t5_after_mispred", {31'd0, out_mispred}, 32'd0);
    chk("t5_after_redirect", out_redirect, 32'h900);
    // 6: redirect wrap at top of address space, counter floor
    drive(1, 32'hFFFF_FFFC, 32'h0, 2'b10, 32'h0, 2'd0, 1'b1, 1'b1);
    step();
    bubble();
    step();
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_redirect", out_redirect, 32'h0);
    chk("t6_mispred", {31'd0, out_mispred}, 32'd1);
    chk("t6_counter", {30'd0, out_counter}, 32'd0);
    chk("t6_btb_wr", {31'd0, out_btb_wr}, 32'd1);
    // reset beats flush and clears data mid-flight
    reset = 1; stg_x = 1;
    step();
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_pc", out_pc, 32'd0);
    chk("rst2_redirect", out_redirect, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
